// File: rtl/mcu_spi_pkg.sv
// ---------------------------------------------------------------------------
// mcu_spi_pkg : shared target codes and constants for the MCU SPI front end
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mcu_spi_pkg;

  typedef enum logic [2:0] {
    TGT_SYS  = 3'd0,
    TGT_HID  = 3'd1,
    TGT_OSD  = 3'd2,
    TGT_SDC  = 3'd3,
    TGT_NONE = 3'd4
  } tgt_e;

  localparam int SYNC_STAGES = 2;

  function automatic tgt_e decode_tgt(input logic [7:0] b);
    tgt_e t;
    case (b)
      8'd0:    t = TGT_SYS;
      8'd1:    t = TGT_HID;
      8'd2:    t = TGT_OSD;
      8'd3:    t = TGT_SDC;
      default: t = TGT_NONE;
    endcase
    return t;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_edge.sv
// ---------------------------------------------------------------------------
// sync_edge : two-flop synchronizer with an extra flop for rise/fall pulses
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_edge
  import mcu_spi_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES:0] pipe_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_q <= {(SYNC_STAGES + 1){RESET_VAL}};
    end else begin
      pipe_q <= {pipe_q[SYNC_STAGES-1:0], pin_i};
    end
  end

  assign level_o = pipe_q[SYNC_STAGES-1];
  assign rise_o  = pipe_q[SYNC_STAGES-1] & ~pipe_q[SYNC_STAGES];
  assign fall_o  = ~pipe_q[SYNC_STAGES-1] & pipe_q[SYNC_STAGES];

endmodule

`default_nettype wire

// File: rtl/mcu_spi_frontend.sv
// ---------------------------------------------------------------------------
// mcu_spi_frontend : oversampled SPI slave, target-select byte then data bytes
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mcu_spi_frontend
  import mcu_spi_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_io_ss,
  input  logic       spi_io_clk,
  input  logic       spi_io_din,
  output logic       spi_io_dout,
  output logic       mcu_sys_strobe,
  output logic       mcu_hid_strobe,
  output logic       mcu_osd_strobe,
  output logic       mcu_sdc_strobe,
  output logic       mcu_start,
  output logic [7:0] mcu_dout,
  input  logic [7:0] mcu_sys_din,
  input  logic [7:0] mcu_hid_din,
  input  logic [7:0] mcu_osd_din,
  input  logic [7:0] mcu_sdc_din
);

  logic w_ss, w_ss_rise_unused, w_ss_fall_unused;
  logic w_sck_unused, w_sck_rise, w_sck_fall;
  logic w_mosi, w_mosi_rise_unused, w_mosi_fall_unused;

  // SS idles high so the front end starts outside a frame after reset
  sync_edge #(.RESET_VAL(1'b1)) u_sync_ss (
    .clk(clk), .reset(reset), .pin_i(spi_io_ss),
    .level_o(w_ss), .rise_o(w_ss_rise_unused), .fall_o(w_ss_fall_unused)
  );

  sync_edge #(.RESET_VAL(1'b0)) u_sync_sck (
    .clk(clk), .reset(reset), .pin_i(spi_io_clk),
    .level_o(w_sck_unused), .rise_o(w_sck_rise), .fall_o(w_sck_fall)
  );

  sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .pin_i(spi_io_din),
    .level_o(w_mosi), .rise_o(w_mosi_rise_unused), .fall_o(w_mosi_fall_unused)
  );

  logic [7:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] dout_q, dout_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [1:0] byte_idx_q, byte_idx_d;
  tgt_e       tgt_q, tgt_d;
  logic [3:0] stb_q, stb_d;
  logic       start_q, start_d;
  logic [1:0] ld_q, ld_d;

  logic [7:0] w_byte;
  logic       w_byte_done;
  logic [7:0] w_reply;

  assign w_byte      = {rx_q[6:0], w_mosi};
  assign w_byte_done = ~w_ss & w_sck_rise & (bit_cnt_q == 3'd7);

  always_comb begin
    w_reply = 8'h00;
    case (tgt_q)
      TGT_SYS: w_reply = mcu_sys_din;
      TGT_HID: w_reply = mcu_hid_din;
      TGT_OSD: w_reply = mcu_osd_din;
      TGT_SDC: w_reply = mcu_sdc_din;
      default: w_reply = 8'h00;
    endcase
  end

  always_comb begin
    rx_d       = rx_q;
    tx_d       = tx_q;
    dout_d     = dout_q;
    bit_cnt_d  = bit_cnt_q;
    byte_idx_d = byte_idx_q;
    tgt_d      = tgt_q;
    stb_d      = 4'b0000;
    start_d    = 1'b0;
    ld_d       = {ld_q[0], w_byte_done};

    if (w_ss) begin
      bit_cnt_d  = 3'd0;
      byte_idx_d = 2'd0;
      tgt_d      = TGT_NONE;
      tx_d       = 8'h00;
    end else begin
      if (w_sck_rise) begin
        rx_d      = w_byte;
        bit_cnt_d = bit_cnt_q + 3'd1;
      end

      if (w_byte_done) begin
        if (byte_idx_q == 2'd0) begin
          tgt_d      = decode_tgt(w_byte);
          byte_idx_d = 2'd1;
        end else begin
          dout_d  = w_byte;
          start_d = (byte_idx_q == 2'd1);
          if (tgt_q != TGT_NONE) begin
            stb_d[tgt_q[1:0]] = 1'b1;
          end
          byte_idx_d = 2'd2;
        end
      end

      // Reply load lags byte_done by two cycles so the consumer can register it
      if (ld_q[1]) begin
        tx_d = w_reply;
      end else if (w_sck_fall && (bit_cnt_q != 3'd0)) begin
        tx_d = {tx_q[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_q       <= 8'h00;
      tx_q       <= 8'h00;
      dout_q     <= 8'h00;
      bit_cnt_q  <= 3'd0;
      byte_idx_q <= 2'd0;
      tgt_q      <= TGT_NONE;
      stb_q      <= 4'b0000;
      start_q    <= 1'b0;
      ld_q       <= 2'b00;
    end else begin
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      dout_q     <= dout_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_idx_q <= byte_idx_d;
      tgt_q      <= tgt_d;
      stb_q      <= stb_d;
      start_q    <= start_d;
      ld_q       <= ld_d;
    end
  end

  assign spi_io_dout    = tx_q[7];
  assign mcu_sys_strobe = stb_q[0];
  assign mcu_hid_strobe = stb_q[1];
  assign mcu_osd_strobe = stb_q[2];
  assign mcu_sdc_strobe = stb_q[3];
  assign mcu_start      = start_q;
  assign mcu_dout       = dout_q;

endmodule

`default_nettype wire
